// File: rtl/vec_load_pkg.sv
// Shared types and width helpers for the vector-load sequencer and its buffer.
package vec_load_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Count width must hold the value MAX_VECS itself, hence the +1.
  function automatic int nv_width(input int max_vecs);
    return $clog2(max_vecs + 1);
  endfunction

  function automatic int vl_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // A single-slot buffer still needs a one-bit address.
  function automatic int idx_width(input int max_vecs);
    return (max_vecs <= 1) ? 1 : $clog2(max_vecs);
  endfunction

endpackage

// File: rtl/vec_buffer.sv
// Register file holding one batch of vectors: one write port, one combinational read port.
module vec_buffer
  import vec_load_pkg::*;
#(
  parameter int MAX_VECS = 16,
  parameter int WIDTH    = 16,
  parameter int IDX_W    = idx_width(MAX_VECS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [MAX_VECS];

  // Contents are deliberately not reset; they are only meaningful once a batch completes.
  for (genvar gi = 0; gi < MAX_VECS; gi++) begin : g_slot
    always_ff @(posedge clk) begin
      if (we && (waddr == IDX_W'(gi))) begin
        mem_q[gi] <= wdata;
      end
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/vec_load_sequencer.sv
// Drives a vector reader once per vector of a batch, masks each captured vector to the
// batch length, buffers it, and hands the finished batch to the solver.
module vec_load_sequencer
  import vec_load_pkg::*;
#(
  parameter int MAX_VEC_LENGTH = 16,
  parameter int AXI_DATA_WIDTH = 8,
  parameter int MAX_VECS       = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic                                abort,
  input  logic [nv_width(MAX_VECS)-1:0]       num_vecs,
  input  logic [vl_width(MAX_VEC_LENGTH)-1:0] vec_length,
  output logic                                busy,
  output logic                                err,
  output logic                                rd_start,
  output logic [vl_width(MAX_VEC_LENGTH)-1:0] rd_vec_length,
  input  logic                                rd_done,
  input  logic [MAX_VEC_LENGTH-1:0]           rd_vec,
  output logic                                job_valid,
  input  logic                                job_ready,
  output logic [nv_width(MAX_VECS)-1:0]       job_count,
  input  logic [idx_width(MAX_VECS)-1:0]      buf_addr,
  output logic [MAX_VEC_LENGTH-1:0]           buf_data
);

  localparam int NV_W  = nv_width(MAX_VECS);
  localparam int VL_W  = vl_width(MAX_VEC_LENGTH);
  localparam int IDX_W = idx_width(MAX_VECS);

  localparam logic [NV_W-1:0]         MAX_VECS_NV = NV_W'(MAX_VECS);
  localparam logic [VL_W-1:0]         MAX_LEN_VL  = VL_W'(MAX_VEC_LENGTH);
  localparam logic [MAX_VEC_LENGTH:0] ONE_EXT     = (MAX_VEC_LENGTH + 1)'(1);

  // The stream width only sizes the reader's chunks; reject nonsensical configurations early.
  if (AXI_DATA_WIDTH < 1 || MAX_VECS < 1 || MAX_VEC_LENGTH < 1) begin : g_bad_cfg
    $error("vec_load_sequencer: widths and counts must be at least 1");
  end

  state_t              state_q, state_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic                rd_start_q, rd_start_d;
  logic                job_valid_q, job_valid_d;
  logic [VL_W-1:0]     vec_len_q, vec_len_d;
  logic [NV_W-1:0]     num_q, num_d;
  logic [IDX_W-1:0]    index_q, index_d;

  logic                      start_ok;
  logic                      last_vec;
  logic                      buf_we;
  logic [MAX_VEC_LENGTH:0]   mask_ext;
  logic [MAX_VEC_LENGTH-1:0] mask;
  logic [MAX_VEC_LENGTH-1:0] buf_wdata;

  assign start_ok = (num_vecs != '0) && (num_vecs <= MAX_VECS_NV) &&
                    (vec_length != '0) && (vec_length <= MAX_LEN_VL);

  assign last_vec = (NV_W'(index_q) == (num_q - NV_W'(1)));

  // One extra bit so a full-length vector shifts to 2^N and yields all-ones; the top
  // bit saturates the mask should the length ever exceed the buffer width.
  assign mask_ext  = (ONE_EXT << vec_len_q) - ONE_EXT;
  assign mask      = mask_ext[MAX_VEC_LENGTH-1:0] | {MAX_VEC_LENGTH{mask_ext[MAX_VEC_LENGTH]}};
  assign buf_wdata = rd_vec & mask;

  always_comb begin
    state_d   = state_q;
    vec_len_d = vec_len_q;
    num_d     = num_q;
    index_d   = index_q;
    err_d     = 1'b0;
    buf_we    = 1'b0;

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (start_ok) begin
              num_d     = num_vecs;
              vec_len_d = vec_length;
              index_d   = '0;
              state_d   = ST_ISSUE;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        ST_ISSUE: state_d = ST_WAIT;
        ST_WAIT: begin
          if (rd_done) begin
            buf_we = 1'b1;
            if (last_vec) begin
              state_d = ST_DONE;
            end else begin
              index_d = index_q + IDX_W'(1);
              state_d = ST_ISSUE;
            end
          end
        end
        ST_DONE: begin
          if (job_ready) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Outputs are registered copies of the next state, so they line up with state_q.
    busy_d      = (state_d != ST_IDLE);
    rd_start_d  = (state_d == ST_ISSUE);
    job_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      rd_start_q  <= 1'b0;
      job_valid_q <= 1'b0;
      vec_len_q   <= '0;
      num_q       <= '0;
      index_q     <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      rd_start_q  <= rd_start_d;
      job_valid_q <= job_valid_d;
      vec_len_q   <= vec_len_d;
      num_q       <= num_d;
      index_q     <= index_d;
    end
  end

  vec_buffer #(
    .MAX_VECS (MAX_VECS),
    .WIDTH    (MAX_VEC_LENGTH),
    .IDX_W    (IDX_W)
  ) u_buffer (
    .clk   (clk),
    .we    (buf_we && rst_n),
    .waddr (index_q),
    .wdata (buf_wdata),
    .raddr (buf_addr),
    .rdata (buf_data)
  );

  assign busy          = busy_q;
  assign err           = err_q;
  assign rd_start      = rd_start_q;
  assign rd_vec_length = vec_len_q;
  assign job_valid     = job_valid_q;
  assign job_count     = num_q;

endmodule

// File: tb/tb_vec_load_sequencer.sv
// Scoreboard bench for vec_load_sequencer: stimulus queues expected events, a negedge
// monitor pops and compares them as the DUT produces rd_start, err, job and buffer reads.
module tb_vec_load_sequencer;

  localparam int NV_W  = 5;
  localparam int VL_W  = 5;
  localparam int IDX_W = 4;

  localparam int K_RDSTART = 0;
  localparam int K_ERR     = 1;
  localparam int K_JOB     = 2;
  localparam int K_BUF     = 3;

  typedef struct {
    int          kind;
    logic [15:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  logic             clk = 1'b0;
  logic             rst_n, start, abort, rd_done, job_ready;
  logic [NV_W-1:0]  num_vecs;
  logic [VL_W-1:0]  vec_length;
  logic [15:0]      rd_vec;
  logic [IDX_W-1:0] buf_addr;
  logic             busy, err, rd_start, job_valid;
  logic [VL_W-1:0]  rd_vec_length;
  logic [NV_W-1:0]  job_count;
  logic [15:0]      buf_data;
  logic             probe_en = 1'b0;
  logic             job_valid_prev = 1'b0;

  always #5 clk = ~clk;

  vec_load_sequencer #(
    .MAX_VEC_LENGTH (16),
    .AXI_DATA_WIDTH (8),
    .MAX_VECS       (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .num_vecs      (num_vecs),
    .vec_length    (vec_length),
    .busy          (busy),
    .err           (err),
    .rd_start      (rd_start),
    .rd_vec_length (rd_vec_length),
    .rd_done       (rd_done),
    .rd_vec        (rd_vec),
    .job_valid     (job_valid),
    .job_ready     (job_ready),
    .job_count     (job_count),
    .buf_addr      (buf_addr),
    .buf_data      (buf_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic expect_evt(input int kind, input logic [15:0] act, input string name);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s unexpected event actual=%0h required=none", name, act);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val !== act) begin
        failures++;
        $display("FAIL %s actual kind=%0d value=%0h required kind=%0d value=%0h",
                 name, kind, act, e.kind, e.val);
      end else begin
        $display("ok   %s value=%0h", name, act);
      end
    end
  endtask

  // Monitor: every DUT-presented event consumes one scoreboard entry.
  always @(negedge clk) begin
    if (err)                       expect_evt(K_ERR, 16'h0, "err_pulse");
    if (rd_start)                  expect_evt(K_RDSTART, 16'(rd_vec_length), "rd_start");
    if (job_valid && !job_valid_prev) expect_evt(K_JOB, 16'(job_count), "job_offer");
    if (probe_en)                  expect_evt(K_BUF, buf_data, "buf_data");
    job_valid_prev = job_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input int val);
    exp_t e;
    e.kind = kind;
    e.val  = 16'(val);
    exp_q.push_back(e);
  endtask

  task automatic start_batch(input int n, input int len, input int n_rd, input bit job);
    for (int i = 0; i < n_rd; i++) push(K_RDSTART, len);
    if (job) push(K_JOB, n);
    num_vecs   = NV_W'(n);
    vec_length = VL_W'(len);
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_rd_start(output bit seen);
    int w;
    w = 0;
    while (!rd_start && w < 50) begin
      tick();
      w++;
    end
    seen = rd_start;
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL rd_start_timeout actual=0 required=1");
    end
  endtask

  // Reader model: answer the pending rd_start after lat cycles.
  task automatic serve(input logic [15:0] v, input int lat, input bit last);
    bit seen;
    wait_rd_start(seen);
    if (seen) begin
      repeat (lat) tick();
      rd_done = 1'b1;
      rd_vec  = v;
      tick();
      rd_done = 1'b0;
      rd_vec  = '0;
      if (last) check("job_valid_after_last_done", job_valid, 1);
    end
  endtask

  task automatic probe(input int addr, input int expv);
    buf_addr = IDX_W'(addr);
    push(K_BUF, expv);
    probe_en = 1'b1;
    tick();
    probe_en = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_rd_start"}, rd_start, 0);
    check({tag, "_job_valid"}, job_valid, 0);
    check({tag, "_rd_vec_length"}, rd_vec_length, 0);
    check({tag, "_job_count"}, job_count, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v;
    bit          seen;
    int          bad_nv [4];
    int          bad_vl [4];

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; rd_done = 1'b0; job_ready = 1'b0;
    num_vecs = '0; vec_length = '0; rd_vec = '0; buf_addr = '0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Nominal batch: 3 vectors of 5 bits.
    start_batch(3, 5, 3, 1);
    serve(16'hFFFF, 4, 0);
    serve(16'h0012, 4, 0);
    serve(16'h0007, 4, 1);
    probe(0, 16'h001F);
    probe(1, 16'h0012);
    probe(2, 16'h0007);

    // Backpressure with spurious start and rd_done while the job is offered.
    for (int i = 0; i < 10; i++) begin
      if (i == 2) begin start = 1'b1; num_vecs = 5'd2; vec_length = 5'd3; end
      if (i == 5) begin rd_done = 1'b1; rd_vec = 16'hAAAA; end
      tick();
      start = 1'b0; rd_done = 1'b0; rd_vec = '0;
      check("job_valid_held", job_valid, 1);
    end
    check("job_count_held", job_count, 3);
    probe(0, 16'h001F);
    probe(1, 16'h0012);
    probe(2, 16'h0007);
    job_ready = 1'b1; start = 1'b1; num_vecs = 5'd2; vec_length = 5'd3;
    tick();
    job_ready = 1'b0; start = 1'b0;
    check("job_valid_after_accept", job_valid, 0);
    check("busy_after_accept", busy, 0);
    tick();
    check("busy_start_ignored_on_accept", busy, 0);

    // Rejected starts.
    bad_nv = '{0, 17, 3, 3};
    bad_vl = '{5, 5, 0, 17};
    for (int i = 0; i < 4; i++) begin
      push(K_ERR, 0);
      num_vecs = NV_W'(bad_nv[i]); vec_length = VL_W'(bad_vl[i]);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("busy_on_reject", busy, 0);
      tick();
    end

    // Full boundary: 16 vectors of 16 bits.
    start_batch(16, 16, 16, 1);
    for (int i = 0; i < 16; i++) begin
      v = 16'hA5C3 ^ 16'(i * 4369);
      serve(v, 1, i == 15);
    end
    for (int i = 0; i < 16; i++) begin
      v = 16'hA5C3 ^ 16'(i * 4369);
      probe(i, int'(v));
    end
    job_ready = 1'b1;
    tick();
    job_ready = 1'b0;
    check("idle_after_full", busy, 0);

    // Abort during the third of four vectors, then restart immediately.
    start_batch(4, 8, 3, 0);
    serve(16'h1234, 4, 0);
    serve(16'h5678, 4, 0);
    wait_rd_start(seen);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("busy_after_abort", busy, 0);
    check("job_valid_after_abort", job_valid, 0);
    start_batch(2, 4, 2, 1);
    serve(16'hABCD, 2, 0);
    serve(16'h00F9, 2, 1);
    probe(0, 16'h000D);
    probe(1, 16'h0009);
    job_ready = 1'b1;
    tick();
    job_ready = 1'b0;
    rd_done = 1'b1; rd_vec = 16'hFFFF;
    tick();
    rd_done = 1'b0; rd_vec = '0;
    check("busy_late_rd_done", busy, 0);
    probe(0, 16'h000D);
    probe(1, 16'h0009);

    // Reset in the middle of a batch.
    start_batch(3, 5, 1, 0);
    wait_rd_start(seen);
    tick();
    rst_n = 1'b0;
    tick();
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    tick();
    check("busy_after_midreset", busy, 0);

    repeat (3) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
